cpu_clock_ctl: RTL
==================

// Module: cpu_clock_ctl
// PURPOSE
//  CPU clock management unit. Sits directly downstream of the debug top level and consumes its cmu_trig_* pulses and cmu_suppress_clock.
//  Produces the single clock-enable (cpu_ce) that gates every CPU state element, which gives halt, free-run, single-step and single-cycle.
//  It also accepts a halt request from the CPU core (EBREAK) and counts enabled cycles for debug.
// PARAMETERS
//  RESET_HALTED   1    1: leave reset in HALT; 0: leave reset in RUN
//  STEP_TIMEOUT   255  max enabled cycles in STEP before forced HALT (>=1)
//  CNT_W          32   width of enabled-cycle counter
// PORTS
//  clk             in   1      system clock (the one clock; CPU shares it via cpu_ce)
//  rst             in   1      synchronous reset, active-high
//  trig_halt       in   1      1-cycle pulse: stop CPU
//  trig_unhalt     in   1      1-cycle pulse: free-run CPU
//  trig_step       in   1      1-cycle pulse: run until one instruction retires
//  trig_cycle      in   1      1-cycle pulse: exactly one enabled CPU cycle
//  suppress_clock  in   1      level: debug busy, force cpu_ce low, state frozen
//  cpu_retire      in   1      CPU retires an instruction this cycle (valid only when cpu_ce=1)
//  cpu_halt_req    in   1      CPU requests halt (EBREAK), sampled only when cpu_ce=1
//  cpu_ce          out  1      CPU clock enable
//  halted          out  1      state==HALT
//  state           out  2      current state encoding (for debug print)
//  step_timeout    out  1      sticky: last STEP ended by timeout
//  en_count        out  CNT_W  number of cycles with cpu_ce=1, wraps modulo 2^CNT_W
// BEHAVIOUR
//  States: HALT=2'd0, RUN=2'd1, STEP=2'd2, CYCLE=2'd3. All outputs except cpu_ce are registered.
//  Reset: state=RESET_HALTED?HALT:RUN, step_timeout=0, en_count=0, step counter=0; cpu_ce follows the state.
//  cpu_ce = (state!=HALT) && !suppress_clock, combinational from the state register and suppress_clock.
//  Trigger latency: a pulse sampled at edge N changes the state at edge N; cpu_ce reflects the new state in cycle N+1.
//  Priority when several events fall in one cycle: trig_halt > trig_unhalt > trig_step > trig_cycle > internal completion.
//  HALT : trig_unhalt->RUN; trig_step->STEP (clear step counter, clear step_timeout); trig_cycle->CYCLE.
//  RUN  : trig_halt->HALT; cpu_halt_req&&cpu_ce->HALT; trig_step/trig_cycle ignored.
//  STEP : trig_halt->HALT; trig_unhalt->RUN.
//         On cpu_ce&&(cpu_retire||cpu_halt_req)->HALT.
//         Else on cpu_ce, increment the step counter; if it reaches STEP_TIMEOUT ->HALT and set step_timeout.
//         Exactly STEP_TIMEOUT enabled cycles occur before a timeout.
//  CYCLE: trig_halt->HALT; trig_unhalt->RUN; otherwise ->HALT on the first cycle with cpu_ce=1.
//         This gives exactly one enabled cycle, however long suppress_clock delays it.
//  suppress_clock=1: cpu_ce=0; cpu_retire/cpu_halt_req ignored; STEP/CYCLE completion and the step counter are frozen.
//         trig_* pulses are still acted on, so a halt issued while suppressed still lands.
//  en_count increments on every cycle with cpu_ce=1 and wraps from all-ones to 0 without any flag.
//  Reset asserted mid-STEP/CYCLE aborts the operation and returns to the reset state the next cycle; no pending trigger survives.
//  Trigger pulses longer than one cycle are re-evaluated every cycle, because the block is level-sensitive by priority.
//  Upstream guarantees single-cycle pulses.
// STRUCTURE
//  Shared package (cmu_pkg): state encodings CMU_HALT/RUN/STEP/CYCLE, and STATE_W=2.
//  The package is also used by the debug UART printer to decode the state field.
//  Single flat module: one state register with next-state logic, a step counter of $clog2(STEP_TIMEOUT+1) bits, and en_count.
//  No sub-module is warranted.
// TESTING
//  1. Reset with RESET_HALTED=1 -> halted=1, cpu_ce=0, en_count=0, state=0 for 10 cycles with no triggers.
//  2. trig_unhalt pulse, run 20 cycles, then trig_halt -> en_count=20 and cpu_ce=0 from the cycle after the halt pulse.
//  3. From HALT, trig_step with cpu_retire asserted on the 3rd enabled cycle -> exactly 3 cpu_ce cycles, halted=1, step_timeout=0.
//  4. STEP_TIMEOUT=8, trig_step, cpu_retire never asserted -> 8 enabled cycles, then HALT with step_timeout=1.
//     A following trig_step clears step_timeout.
//  5. trig_cycle while suppress_clock=1 for 5 cycles -> cpu_ce=0 throughout.
//     After suppress drops, exactly one cpu_ce cycle, then HALT; en_count +1.
//  6. In RUN, trig_halt and trig_step in the same cycle -> HALT.
//     Then cpu_halt_req during RUN -> HALT after that enabled cycle.
//     Then rst mid-STEP -> reset state, en_count=0.

Source files
------------

// File: rtl/cmu_pkg.sv
// Shared CPU clock-management definitions: state encodings for the clock-enable FSM,
// also decoded by the debug UART printer.
package cmu_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        CMU_HALT  = 2'd0,
        CMU_RUN   = 2'd1,
        CMU_STEP  = 2'd2,
        CMU_CYCLE = 2'd3
    } cmu_state_e;

endpackage

// File: rtl/cpu_clock_ctl.sv
// CPU clock management unit: turns debug trigger pulses and CPU halt requests into the
// single CPU clock enable, and counts enabled cycles.
module cpu_clock_ctl
    import cmu_pkg::*;
#(
    parameter bit RESET_HALTED = 1'b1,
    parameter int STEP_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trig_halt,
    input  logic               trig_unhalt,
    input  logic               trig_step,
    input  logic               trig_cycle,
    input  logic               suppress_clock,
    input  logic               cpu_retire,
    input  logic               cpu_halt_req,
    output logic               cpu_ce,
    output logic               halted,
    output logic [STATE_W-1:0] state,
    output logic               step_timeout,
    output logic [CNT_W-1:0]   en_count
);

    localparam int              SC_W        = $clog2(STEP_TIMEOUT + 1);
    localparam logic [SC_W-1:0] STEP_MAX    = SC_W'(STEP_TIMEOUT);
    localparam cmu_state_e      RESET_STATE = RESET_HALTED ? CMU_HALT : CMU_RUN;

    cmu_state_e      state_r;
    cmu_state_e      next_state_s;
    logic            halted_r;
    logic [SC_W-1:0] step_cnt_r;
    logic [SC_W-1:0] step_cnt_next_s;
    logic [SC_W-1:0] step_cnt_inc_s;
    logic            step_timeout_r;
    logic            step_timeout_next_s;
    logic [CNT_W-1:0] en_count_r;
    logic            cpu_ce_s;

    // Clock enable is the only combinational output: suppress must bite in the same cycle.
    always_comb begin
        cpu_ce_s       = (state_r != CMU_HALT) && !suppress_clock;
        step_cnt_inc_s = step_cnt_r + SC_W'(1);
    end

    // Next-state logic; trigger priority is halt > unhalt > step > cycle > completion.
    always_comb begin
        next_state_s        = state_r;
        step_cnt_next_s     = step_cnt_r;
        step_timeout_next_s = step_timeout_r;
        case (state_r)
            CMU_HALT: begin
                if (trig_halt) begin
                    next_state_s = CMU_HALT;
                end else if (trig_unhalt) begin
                    next_state_s = CMU_RUN;
                end else if (trig_step) begin
                    next_state_s        = CMU_STEP;
                    step_cnt_next_s     = {SC_W{1'b0}};
                    step_timeout_next_s = 1'b0;
                end else if (trig_cycle) begin
                    next_state_s = CMU_CYCLE;
                end else begin
                    next_state_s = CMU_HALT;
                end
            end
            CMU_RUN: begin
                if (trig_halt || (cpu_ce_s && cpu_halt_req)) begin
                    next_state_s = CMU_HALT;
                end else begin
                    next_state_s = CMU_RUN;
                end
            end
            CMU_STEP: begin
                if (trig_halt) begin
                    next_state_s = CMU_HALT;
                end else if (trig_unhalt) begin
                    next_state_s = CMU_RUN;
                end else if (cpu_ce_s && (cpu_retire || cpu_halt_req)) begin
                    next_state_s = CMU_HALT;
                end else if (cpu_ce_s) begin
                    // The counter is only frozen by suppress, never by a retire-less cycle.
                    step_cnt_next_s = step_cnt_inc_s;
                    if (step_cnt_inc_s == STEP_MAX) begin
                        next_state_s        = CMU_HALT;
                        step_timeout_next_s = 1'b1;
                    end else begin
                        next_state_s = CMU_STEP;
                    end
                end else begin
                    next_state_s = CMU_STEP;
                end
            end
            CMU_CYCLE: begin
                if (trig_halt) begin
                    next_state_s = CMU_HALT;
                end else if (trig_unhalt) begin
                    next_state_s = CMU_RUN;
                end else if (cpu_ce_s) begin
                    next_state_s = CMU_HALT;
                end else begin
                    next_state_s = CMU_CYCLE;
                end
            end
            default: begin
                next_state_s = CMU_HALT;
            end
        endcase
    end

    // State, status and enabled-cycle counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= RESET_STATE;
            halted_r       <= (RESET_STATE == CMU_HALT);
            step_cnt_r     <= {SC_W{1'b0}};
            step_timeout_r <= 1'b0;
            en_count_r     <= {CNT_W{1'b0}};
        end else begin
            state_r        <= next_state_s;
            halted_r       <= (next_state_s == CMU_HALT);
            step_cnt_r     <= step_cnt_next_s;
            step_timeout_r <= step_timeout_next_s;
            if (cpu_ce_s) begin
                en_count_r <= en_count_r + CNT_W'(1);
            end else begin
                en_count_r <= en_count_r;
            end
        end
    end

    assign cpu_ce       = cpu_ce_s;
    assign halted       = halted_r;
    assign state        = state_r;
    assign step_timeout = step_timeout_r;
    assign en_count     = en_count_r;

endmodule
